apb3_master_bridge: RTL and testbench

- Single-transfer APB3 initiator (requester). Converts a valid/ready command channel from local logic into APB3 SETUP/ACCESS cycles on a 16-slave bus, and returns read data, PSLVERR and timeout status on a valid/ready response channel.
- Drives the bus that the team's APB monitor and assertion checkers observe.
- Output must satisfy those checks: PSEL one-hot-or-zero, PENABLE high exactly one cycle after SETUP, PADDR/PWRITE/PWDATA/PSEL stable through the transfer.

---
 rtl/apb3_master_bridge.sv | 112 +++++++++++
 tb/tb_apb3_master_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_master_bridge.sv
// Single-transfer APB3 requester: turns a valid/ready command into one SETUP/ACCESS
// sequence on a 16-slave bus and returns data, error and timeout status as a response.
module apb3_master_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slverr,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [15:0] PSEL,
  output logic        PWRITE,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] counter;
  logic          timed_out;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    timed_out = TO_EN && (counter == LAST);
    case (state)
      IDLE: begin
        cmd_ready = !PRESET;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timed_out) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  // Bus and response registers; PADDR/PWRITE/PWDATA keep their last value between transfers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PADDR       <= '0;
      PWDATA      <= '0;
      PSEL        <= '0;
      PWRITE      <= 1'b0;
      PENABLE     <= 1'b0;
      counter     <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PSEL   <= 16'(1) << cmd_sel;
            if (cmd_write) PWDATA <= cmd_wdata;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          counter <= '0;
        end
        ACCESS: begin
          // A ready slave on the last permitted cycle still completes normally.
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
          end else if (timed_out) begin
            rsp_rdata   <= 32'h0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Scoreboard bench for apb3_master_bridge: a slave model with programmable wait states,
// a bus/response monitor on the falling edge, and directed command sequences.
module tb_apb3_master_bridge;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [15:0] PSEL;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  apb3_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    int          acc;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
    int          acc_cyc;
    int          lat;
  } rsp_exp_t;

  bus_exp_t busq[$];
  rsp_exp_t rspq[$];
  bus_exp_t cur;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_wdata = '0;

  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Slave model: ready after slv_wait ACCESS cycles (never if negative); noise elsewhere.
  initial begin
    int s_cnt = 0;
    forever begin
      tick();
      if (PSEL != 16'h0 && PENABLE) begin
        if (slv_wait >= 0 && s_cnt == slv_wait) begin
          PREADY  = 1'b1;
          PRDATA  = slv_rdata;
          PSLVERR = slv_err;
        end else begin
          PREADY  = 1'b0;
          PRDATA  = $urandom;
          PSLVERR = 1'b1;
        end
        s_cnt++;
      end else begin
        s_cnt   = 0;
        PREADY  = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        PSLVERR = 1'b1;
      end
    end
  end

  // Monitor: protocol invariants, per-transfer bus values and response scoreboard.
  initial begin
    logic [15:0] prev_psel = '0;
    logic [31:0] prev_paddr = '0;
    logic [31:0] prev_pwdata = '0;
    logic        prev_pwrite = 1'b0;
    logic        prev_rv = 1'b0;
    logic        prev_rr = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_slverr = 1'b0;
    logic        prev_timeout = 1'b0;
    int          acc_cnt = 0;
    rsp_exp_t    r;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        prev_psel = '0;
        prev_rv   = 1'b0;
        acc_cnt   = 0;
        continue;
      end
      checkOutput("psel_onehot0", 32'($onehot0(PSEL)), 32'd1);
      checkOutput("penable", 32'(PENABLE), 32'((PSEL != 16'h0) && (prev_psel != 16'h0)));
      checkOutput("cmd_ready", 32'(cmd_ready), 32'((PSEL == 16'h0) && !rsp_valid));
      if (PSEL != 16'h0 && prev_psel == 16'h0) begin
        checkOutput("setup_expected", 32'(busq.size()), 32'd1);
        if (busq.size() > 0) begin
          cur = busq.pop_front();
          checkOutput("psel", 32'(PSEL), 32'(cur.psel));
          checkOutput("paddr", PADDR, cur.paddr);
          checkOutput("pwrite", 32'(PWRITE), 32'(cur.pwrite));
          checkOutput("pwdata", PWDATA, cur.pwdata);
        end
        acc_cnt = 0;
      end
      if (PSEL != 16'h0 && prev_psel != 16'h0) begin
        checkOutput("psel_stable", 32'(PSEL), 32'(prev_psel));
        checkOutput("paddr_stable", PADDR, prev_paddr);
        checkOutput("pwrite_stable", 32'(PWRITE), 32'(prev_pwrite));
        checkOutput("pwdata_stable", PWDATA, prev_pwdata);
        acc_cnt++;
      end
      if (PSEL == 16'h0 && prev_psel != 16'h0)
        checkOutput("access_cycles", 32'(acc_cnt), 32'(cur.acc));
      if (rsp_valid) begin
        checkOutput("psel_in_resp", 32'(PSEL), 32'h0);
        if (!prev_rv && rspq.size() > 0)
          checkOutput("rsp_latency", 32'(cyc - rspq[0].acc_cyc), 32'(rspq[0].lat));
        if (prev_rv && !prev_rr) begin
          checkOutput("rsp_rdata_stable", rsp_rdata, prev_rdata);
          checkOutput("rsp_slverr_stable", 32'(rsp_slverr), 32'(prev_slverr));
          checkOutput("rsp_timeout_stable", 32'(rsp_timeout), 32'(prev_timeout));
        end
        if (rsp_ready) begin
          checkOutput("rsp_expected", 32'(rspq.size()), 32'd1);
          if (rspq.size() > 0) begin
            r = rspq.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, r.rdata);
            checkOutput("rsp_slverr", 32'(rsp_slverr), 32'(r.slverr));
            checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(r.timeout));
          end
        end
      end
      prev_psel    = PSEL;
      prev_paddr   = PADDR;
      prev_pwdata  = PWDATA;
      prev_pwrite  = PWRITE;
      prev_rv      = rsp_valid;
      prev_rr      = rsp_ready;
      prev_rdata   = rsp_rdata;
      prev_slverr  = rsp_slverr;
      prev_timeout = rsp_timeout;
    end
  end

  // Offers one command, pushes its expected bus and response values on acceptance.
  task automatic applyStimulus(input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                               input logic [31:0] wdata, input int waits, input logic err,
                               input logic [31:0] rdata, input bit keep, output int acc_at);
    int n = 0;
    bus_exp_t b;
    rsp_exp_t r;
    bit tmo;
    slv_wait  = waits;
    slv_err   = err;
    slv_rdata = rdata;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_sel   = sel;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && n < 64) begin
      tick();
      n++;
    end
    checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
    acc_at = cyc;
    if (cmd_ready) begin
      tmo = (waits < 0) || (waits >= TO);
      if (wr) last_wdata = wdata;
      b.psel   = 16'(1) << sel;
      b.paddr  = addr;
      b.pwrite = wr;
      b.pwdata = last_wdata;
      b.acc    = tmo ? TO : waits + 1;
      busq.push_back(b);
      r.rdata   = (tmo || wr) ? 32'h0 : rdata;
      r.slverr  = tmo ? 1'b1 : err;
      r.timeout = tmo;
      r.acc_cyc = cyc;
      r.lat     = 2 + b.acc;
      rspq.push_back(r);
    end
    tick();
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_sel   = 4'($urandom_range(0, 15));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((rspq.size() != 0 || !cmd_ready) && n < 64) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", 32'(n < 64), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_psel"}, 32'(PSEL), 32'h0);
    checkOutput({tag, "_penable"}, 32'(PENABLE), 32'h0);
    checkOutput({tag, "_paddr"}, PADDR, 32'h0);
    checkOutput({tag, "_pwdata"}, PWDATA, 32'h0);
    checkOutput({tag, "_pwrite"}, 32'(PWRITE), 32'h0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    checkOutput({tag, "_rsp_slverr"}, 32'(rsp_slverr), 32'h0);
    checkOutput({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'h0);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, a1, a2;
    PRESET = 1'b1;
    repeat (3) tick();
    checkResetValues("reset");
    PRESET = 1'b0;
    #1;
    checkOutput("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    tick();

    $display("[TB] write, zero wait states");
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 4'd3, 32'h0000_1004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0, a0);
    waitIdle();

    $display("[TB] read, three wait states");
    applyStimulus(1'b0, 4'd15, 32'h0000_0040, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0, a0);
    waitIdle();

    $display("[TB] slave error with stalled response");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'd5, 32'h0000_0200, 32'h0, 1, 1'b1, 32'hA5A5_0001, 1'b0, a0);
    begin
      int n = 0;
      while (!rsp_valid && n < 32) begin
        tick();
        n++;
      end
      checkOutput("slverr_rsp_seen", 32'(rsp_valid), 32'd1);
    end
    repeat (5) begin
      tick();
      checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("hold_psel", 32'(PSEL), 32'd0);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    waitIdle();
    applyStimulus(1'b1, 4'd7, 32'h0000_0300, 32'h0BAD_F00D, 2, 1'b1, 32'h0, 1'b0, a0);
    waitIdle();

    $display("[TB] timeout and last-cycle completion");
    applyStimulus(1'b0, 4'd2, 32'h0000_0044, 32'h0, -1, 1'b0, 32'h7777_7777, 1'b0, a0);
    waitIdle();
    applyStimulus(1'b0, 4'd4, 32'h0000_0048, 32'h0, 3, 1'b1, 32'h1357_9BDF, 1'b0, a0);
    waitIdle();

    $display("[TB] back-to-back commands");
    applyStimulus(1'b1, 4'd1, 32'h0000_1000, 32'h1111_2222, 0, 1'b0, 32'hFEED_0001, 1'b1, a0);
    applyStimulus(1'b0, 4'd8, 32'h0000_2000, 32'h0, 0, 1'b0, 32'hFEED_0001, 1'b1, a1);
    applyStimulus(1'b1, 4'd12, 32'h0000_3000, 32'h3333_4444, 0, 1'b0, 32'hFEED_0001, 1'b0, a2);
    checkOutput("b2b_spacing_1", 32'(a1 - a0), 32'd4);
    checkOutput("b2b_spacing_2", 32'(a2 - a1), 32'd4);
    waitIdle();

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b1, 4'd9, 32'h0000_0ABC, 32'h55AA_55AA, -1, 1'b0, 32'h0, 1'b0, a0);
    tick();
    tick();
    checkOutput("pre_reset_penable", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    rspq.delete();
    busq.delete();
    last_wdata = 32'h0;
    tick();
    checkResetValues("midreset");
    PRESET = 1'b0;
    #1;
    checkOutput("cmd_ready_after_midreset", 32'(cmd_ready), 32'd1);
    tick();
    repeat (6) begin
      tick();
      checkOutput("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(1'b0, 4'd0, 32'h0000_0008, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, a0);
    waitIdle();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
